serial_subtractor: RTL and testbench

- Bit-serial A − B − Bin unit. It is the inverse operation of the ALU's ripple-carry adder case.
- It processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- The start/busy/done handshake lets the ALU select logic or a board-level wrapper (SW in, LEDR out) launch an operation and sample the result.
- Trades area for latency: one cell instead of WIDTH cells.

---
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor computing (a - b - bin) mod 2^WIDTH, one bit per
// clock, LSB first, through a single full-subtractor cell and a borrow flop.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset
//   start  - launch request; accepted in IDLE or DONE
//   a, b   - minuend / subtrahend, captured on an accepted start
//   bin    - borrow-in, captured on an accepted start
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when diff/bout are newly valid
//   diff   - registered difference
//   bout   - registered borrow-out (1 when a < b + bin)
//   ovf    - signed overflow flag (only when SERIAL_SUB_OVF_EN is defined)
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf output and two
// flops that hold the captured operand sign bits.

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] sd_reg;
  logic             br_reg;
  logic [CW-1:0]    count_reg;

  // Full-subtractor cell operating on the current LSBs.
  logic             bit_x;
  logic             bit_y;
  logic             d_next;
  logic             br_next;
  logic [WIDTH-1:0] sd_next;

  always_comb begin
    bit_x   = sa_reg[0];
    bit_y   = sb_reg[0];
    d_next  = bit_x ^ bit_y ^ br_reg;
    br_next = (~bit_x & bit_y) | (~bit_x & br_reg) | (bit_y & br_reg);
    sd_next = {d_next, sd_reg[WIDTH-1:1]};
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_reg;
  logic b_msb_reg;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      sd_reg    <= '0;
      br_reg    <= 1'b0;
      count_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            br_reg    <= bin;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
`endif
          end else begin
            state_reg <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately ignored here; operands stay untouched.
          br_reg    <= br_next;
          sd_reg    <= sd_next;
          sa_reg    <= sa_reg >> 1;
          sb_reg    <= sb_reg >> 1;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_COUNT) begin
            // Publish using the final cell outputs of this same edge.
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            diff      <= sd_next;
            bout      <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= (a_msb_reg != b_msb_reg) && (d_next != a_msb_reg);
`endif
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .bin(bin),
    .busy(busy),
    .done(done),
    .diff(diff),
    .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clock = ~clock;

  // Drive a one-cycle start pulse; returns at the negedge after the
  // accepting edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    @(negedge clock);
    a = av; b = bv; bin = bv_in; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Count negedges until done is seen (bounded at 20).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if ({busy, done, diff, bout} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b want all 0", busy, done, diff, bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    reset = 1'b0;
    $display("reset: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
  endtask

  task automatic test_basic;
    int n;
    int busy_cycles;
    launch(4'd9, 4'd3, 1'b0);
    n = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clock);
      n++;
    end
    total++;
    if (n != W) begin
      bad++;
      $display("FAIL basic_latency: got %0d edges want %0d", n, W);
    end
    total++;
    if (busy_cycles != W) begin
      bad++;
      $display("FAIL basic_busy_cycles: got %0d want %0d", busy_cycles, W);
    end
    total++;
    if (diff !== 4'd6 || bout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got diff=%h bout=%b busy=%b want diff=6 bout=0 busy=0", diff, bout, busy);
    end
    @(negedge clock);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later want 0", done);
    end
    $display("basic 9-3-0: diff=%h bout=%b latency=%0d busy=%0d", diff, bout, n, busy_cycles);
  endtask

  task automatic test_borrow;
    int n;
    launch(4'd3, 4'd9, 1'b0);
    wait_done(n);
    total++;
    if (n != W || diff !== 4'hA || bout !== 1'b1) begin
      bad++;
      $display("FAIL borrow_3_9: got n=%0d diff=%h bout=%b want n=4 diff=a bout=1", n, diff, bout);
    end
    $display("borrow 3-9-0: diff=%h bout=%b", diff, bout);
    launch(4'd0, 4'd0, 1'b1);
    // Previous result must hold while the new operation runs.
    total++;
    if (busy !== 1'b1 || diff !== 4'hA || bout !== 1'b1) begin
      bad++;
      $display("FAIL hold_during_run: got busy=%b diff=%h bout=%b want busy=1 diff=a bout=1", busy, diff, bout);
    end
    wait_done(n);
    total++;
    if (n != W || diff !== 4'hF || bout !== 1'b1) begin
      bad++;
      $display("FAIL borrow_0_0_1: got n=%0d diff=%h bout=%b want n=4 diff=f bout=1", n, diff, bout);
    end
    $display("borrow 0-0-1: diff=%h bout=%b", diff, bout);
  endtask

  task automatic test_back_to_back;
    int first_t;
    int second_t;
    int pulses;
    logic [W-1:0] d1, d2;
    logic         b1, b2;
    first_t = -1; second_t = -1; pulses = 0;
    d1 = '1; d2 = '1; b1 = 1'b1; b2 = 1'b1;
    @(negedge clock);
    a = 4'd15; b = 4'd15; bin = 1'b0; start = 1'b1;
    @(negedge clock);
    a = 4'd8; b = 4'd1; bin = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (done === 1'b1) begin
        pulses++;
        if (first_t < 0) begin
          first_t = t; d1 = diff; b1 = bout;
        end else if (second_t < 0) begin
          second_t = t; d2 = diff; b2 = bout;
          start = 1'b0;
        end
      end
      @(negedge clock);
    end
    start = 1'b0;
    total++;
    if (first_t != W || second_t != 2 * W + 1 || pulses != 2) begin
      bad++;
      $display("FAIL b2b_timing: got first=%0d second=%0d pulses=%0d want 4 9 2", first_t, second_t, pulses);
    end
    total++;
    if (d1 !== 4'd0 || b1 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: got diff=%h bout=%b want 0 0", d1, b1);
    end
    total++;
    if (d2 !== 4'd6 || b2 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: got diff=%h bout=%b want 6 0", d2, b2);
    end
    $display("back_to_back: done at %0d and %0d, results %h/%b %h/%b", first_t, second_t, d1, b1, d2, b2);
  endtask

  task automatic test_start_during_run;
    int n;
    int extra;
    launch(4'd9, 4'd3, 1'b0);
    a = 4'd5; b = 4'd5; bin = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a = 4'd0; b = 4'd0; bin = 1'b0;
    wait_done(n);
    total++;
    if (n != W - 1 || diff !== 4'd6 || bout !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_result: got n=%0d diff=%h bout=%b want n=3 diff=6 bout=0", n, diff, bout);
    end
    extra = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_start_extra: got %0d extra busy/done cycles want 0", extra);
    end
    $display("start_during_run: diff=%h bout=%b extra=%0d", diff, bout, extra);
  endtask

  task automatic test_reset_mid_run;
    int n;
    int pulses;
    launch(4'd9, 4'd3, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd0 || bout !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b diff=%h bout=%b want 0 0 0 0", busy, done, diff, bout);
    end
    pulses = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clock);
      if (done === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
    end
    launch(4'd5, 4'd2, 1'b0);
    wait_done(n);
    total++;
    if (n != W || diff !== 4'd3 || bout !== 1'b0) begin
      bad++;
      $display("FAIL after_abort: got n=%0d diff=%h bout=%b want n=4 diff=3 bout=0", n, diff, bout);
    end
    $display("reset_mid_run: then 5-2-0 diff=%h bout=%b", diff, bout);
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf;
    int n;
    launch(4'd7, 4'd8, 1'b0);
    wait_done(n);
    total++;
    if (diff !== 4'hF || bout !== 1'b1 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_7_8: got diff=%h bout=%b ovf=%b want f 1 1", diff, bout, ovf);
    end
    $display("ovf 7-8-0: diff=%h bout=%b ovf=%b", diff, bout, ovf);
    launch(4'd4, 4'd2, 1'b0);
    wait_done(n);
    total++;
    if (diff !== 4'd2 || bout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_4_2: got diff=%h bout=%b ovf=%b want 2 0 0", diff, bout, ovf);
    end
    $display("ovf 4-2-0: diff=%h bout=%b ovf=%b", diff, bout, ovf);
  endtask
`endif

  task automatic test_sweep;
    int n;
    int errs;
    logic [W:0]   exp_full;
    logic [W-1:0] av, bv;
    errs = 0;
    for (int i = 0; i < 512; i++) begin
      av = W'(i[3:0]);
      bv = W'(i[7:4]);
      exp_full = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, i[8]};
      launch(av, bv, i[8]);
      wait_done(n);
      total++;
      if (n != W || {bout, diff} !== exp_full) begin
        bad++; errs++;
        $display("FAIL sweep a=%h b=%h bin=%b: got n=%0d bout=%b diff=%h want bout=%b diff=%h",
                 av, bv, i[8], n, bout, diff, exp_full[W], exp_full[W-1:0]);
      end
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (ovf !== ((av[W-1] != bv[W-1]) && (exp_full[W-1] != av[W-1]))) begin
        bad++; errs++;
        $display("FAIL sweep_ovf a=%h b=%h bin=%b: got %b", av, bv, i[8], ovf);
      end
`endif
    end
    $display("sweep: 512 combinations, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
